m3ds_sram_bank_array: RTL and testbench
=======================================

Name: m3ds_sram_bank_array

Overview:
- Parametrised banked SRAM array for one AHB2SRAM port of the IoT subsystem.
- Generalises the fixed two-bank, 13-bit-address SRAM slice to NUM_BANKS banks of 2^BANK_AW words each.
- Decodes the bank from the upper address bits and muxes read data with a registered bank select.
- Adds a hardware initialisation engine that fills every word with INIT_VALUE after reset or on request, and signals completion on SRAMREADY.

Parameters:
BANK_AW, 12, word-address width of each bank; each bank holds 2^BANK_AW x 32-bit words.
NUM_BANKS, 2, number of banks; legal values are 2, 4, 8 or 16. NBW = log2(NUM_BANKS). AW = BANK_AW + NBW.
INIT_EN, 1, 1 = initialisation engine present; 0 = engine absent and array usable directly after reset.
INIT_VALUE, 32'h0000_0000, word written to every location during initialisation.

Ports:
SRAMHCLK  input  1  clock for the array and all control logic.
SRAMHRESETn  input  1  asynchronous active-low reset.
SRAMADDR  input  AW  word address; [AW-1:BANK_AW] selects the bank, [BANK_AW-1:0] is the in-bank address.
SRAMWDATA  input  32  write data.
SRAMWREN  input  4  byte write enables; 0000 = read.
SRAMCS  input  1  access request, sampled on the rising edge.
SRAMRDATA  output  32  read data, valid one cycle after an accepted read.
INITREQ  input  1  single-cycle pulse that requests re-initialisation.
SRAMREADY  output  1  1 = array idle and accepting accesses.

Behaviour:
- Banks: NUM_BANKS instances of cmsdk_fpga_sram (AW=BANK_AW), all clocked by SRAMHCLK.
- States: INIT and IDLE.
  - Reset: state = INIT if INIT_EN=1, otherwise IDLE.
  - SRAMREADY = (state==IDLE), driven from a register.
  - Reset values: SRAMREADY = 0 (INIT_EN=1) or 1 (INIT_EN=0); init counter = 0; bank_sel = 0; init_q = 1 (INIT_EN=1) or 0 (INIT_EN=0).
- INIT state:
  - Each cycle, all banks are chip-selected with WREN=1111, ADDR=counter and WDATA=INIT_VALUE.
  - The counter increments by 1 per cycle.
  - When counter == 2^BANK_AW-1: next state = IDLE and the counter wraps to 0.
  - SRAMREADY rises exactly 2^BANK_AW rising edges after reset deassertion (4096 at default).
  - SRAMCS is ignored in INIT: no write reaches the array and bank_sel is not updated.
  - INITREQ is ignored in INIT; the sequence neither restarts nor extends.
- IDLE state:
  - Bank b CS = SRAMCS & (SRAMADDR[AW-1:BANK_AW]==b). No other bank is selected.
  - ADDR, WDATA and WREN are broadcast to all banks.
  - When SRAMCS=1, bank_sel <= SRAMADDR[AW-1:BANK_AW]. When SRAMCS=0, bank_sel holds, so SRAMRDATA keeps the last selected bank's output.
  - INITREQ=1 with INIT_EN=1: next state = INIT and counter = 0.
  - INITREQ has priority over a same-cycle SRAMCS. That access is still performed, because the bank CS terms are decoded combinationally from the current state, which is IDLE. The following cycle starts the fill at address 0.
  - INITREQ is ignored when INIT_EN=0.
- Read data:
  - Read latency is 1 cycle.
  - SRAMRDATA = init_q ? 32'h0 : rdata[bank_sel], where init_q <= (state==INIT).
  - SRAMRDATA is therefore 0 in every cycle following an INIT cycle, including the first cycle after SRAMREADY rises.
- Read after write: a read of the same address in the cycle after a write returns the new data (the primitive performs a write-then-read sequence).
- Reset mid-operation:
  - Any assertion of SRAMHRESETn=0 aborts the fill and returns to reset values.
  - The fill restarts from address 0 after release.
  - Array contents are not cleared by reset itself.
- The software contract is to wait for SRAMREADY=1 before issuing accesses; accesses issued earlier are dropped.

Test Plan:
- Defaults with NUM_BANKS=4 (AW=14): release reset -> SRAMREADY=0 for 4095 edges and 1 after edge 4096; reads of 0x0000, 0x1FFF, 0x3FFF then return 0x00000000.
- After ready: write 0xDEADBEEF to 0x3FFF and 0x12345678 to 0x0000, then back-to-back reads 0x3FFF, 0x0000, 0x3FFF -> SRAMRDATA 0xDEADBEEF, 0x12345678, 0xDEADBEEF on consecutive cycles, checking bank_sel switches every cycle.
- Byte lanes: write 0xFFFFFFFF to 0x1004 with WREN=1111, then 0x000000AA with WREN=0001 -> read returns 0xFFFFFFAA; the same in-bank address 0x0004 in the other banks is unchanged.
- INITREQ pulse in IDLE after writes -> SRAMREADY=0 next cycle for 4096 cycles; a write attempted at 0x2000 during INIT is dropped; after ready, all previously written locations read 0x00000000.
- Reset asserted at init counter = 100, released 3 cycles later -> SRAMREADY returns after a full 4096 cycles.
- Build with INIT_EN=0 and NUM_BANKS=2, BANK_AW=10 -> SRAMREADY=1 out of reset; a write/read to 0x7FF round-trips with 1-cycle latency; INITREQ has no effect.

Source files
------------

// File: rtl/m3ds_sram_bank_array_if.sv
// SRAM bank array access port.
// Carries the word address, write data, byte enables, chip select, read data and init handshake.
interface m3ds_sram_bank_array_if #(
  parameter int unsigned AW = 13
);
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMWREN;
  logic          SRAMCS;
  logic [31:0]   SRAMRDATA;
  logic          INITREQ;
  logic          SRAMREADY;

  modport master (
    output SRAMADDR,
    output SRAMWDATA,
    output SRAMWREN,
    output SRAMCS,
    output INITREQ,
    input  SRAMRDATA,
    input  SRAMREADY
  );

  modport slave (
    input  SRAMADDR,
    input  SRAMWDATA,
    input  SRAMWREN,
    input  SRAMCS,
    input  INITREQ,
    output SRAMRDATA,
    output SRAMREADY
  );
endinterface

// File: rtl/m3ds_sram_bank_array.sv
// Banked SRAM array with bank decode, registered read mux and
// a fill engine that writes INIT_VALUE everywhere after reset or on request.

module cmsdk_fpga_sram #(
  parameter int unsigned AW = 16
) (
  input  logic          CLK,
  input  logic [AW-1:0] ADDR,
  input  logic [31:0]   WDATA,
  input  logic [3:0]    WREN,
  input  logic          CS,
  output logic [31:0]   RDATA
);
  logic [31:0]   ram_q [2**AW];
  logic [AW-1:0] addr_q;

  // byte-lane write, then latch address so a following read sees new data
  always_ff @(posedge CLK) begin
    if (CS) begin
      for (int i = 0; i < 4; i++) begin
        if (WREN[i]) begin
          ram_q[ADDR][i*8 +: 8] <= WDATA[i*8 +: 8];
        end
      end
      addr_q <= ADDR;
    end
  end

  assign RDATA = ram_q[addr_q];
endmodule

module m3ds_sram_bank_array #(
  parameter int unsigned BANK_AW    = 12,
  parameter int unsigned NUM_BANKS  = 2,
  parameter bit          INIT_EN    = 1'b1,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input logic                   SRAMHCLK,
  input logic                   SRAMHRESETn,
  m3ds_sram_bank_array_if.slave bus
);
  localparam int unsigned NBW = $clog2(NUM_BANKS);
  localparam int unsigned AW  = BANK_AW + NBW;
  localparam logic [BANK_AW-1:0] CNT_LAST = '1;

  typedef enum logic {
    S_INIT = 1'b0,
    S_IDLE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [BANK_AW-1:0] cnt_q, cnt_d;
  logic [NBW-1:0]     bsel_q, bsel_d;
  logic               init_q;
  logic               ready_q;
  logic [NBW-1:0]     bank_idx;
  logic               in_init;
  logic [NUM_BANKS-1:0] bank_cs;
  logic [BANK_AW-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_wren;
  logic [31:0]        rdata [NUM_BANKS];

  assign bank_idx = bus.SRAMADDR[AW-1:BANK_AW];
  assign in_init  = (state_q == S_INIT);

  // state, fill counter, read bank select and status registers
  always_ff @(posedge SRAMHCLK or negedge SRAMHRESETn) begin
    if (!SRAMHRESETn) begin
      state_q <= INIT_EN ? S_INIT : S_IDLE;
      cnt_q   <= '0;
      bsel_q  <= '0;
      init_q  <= INIT_EN;
      ready_q <= !INIT_EN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bsel_q  <= bsel_d;
      init_q  <= in_init;
      ready_q <= (state_d == S_IDLE);
    end
  end

  // next state: fill runs once over the bank depth; INITREQ restarts it from idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bsel_d  = bsel_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.SRAMCS) begin
          bsel_d = bank_idx;
        end
        if (INIT_EN && bus.INITREQ) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // bank strobes: all banks written together while filling, else one-hot decode
  always_comb begin
    bank_cs   = '0;
    mem_addr  = bus.SRAMADDR[BANK_AW-1:0];
    mem_wdata = bus.SRAMWDATA;
    mem_wren  = bus.SRAMWREN;
    if (in_init) begin
      bank_cs   = '1;
      mem_addr  = cnt_q;
      mem_wdata = INIT_VALUE;
      mem_wren  = 4'hF;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_cs[b] = bus.SRAMCS && (bank_idx == NBW'(b));
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    cmsdk_fpga_sram #(
      .AW (BANK_AW)
    ) u_sram (
      .CLK   (SRAMHCLK),
      .ADDR  (mem_addr),
      .WDATA (mem_wdata),
      .WREN  (mem_wren),
      .CS    (bank_cs[g]),
      .RDATA (rdata[g])
    );
  end

  assign bus.SRAMRDATA = init_q ? 32'h0 : rdata[bsel_q];
  assign bus.SRAMREADY = ready_q;
endmodule

// File: tb/tb_m3ds_sram_bank_array.sv
// Bench for the banked SRAM array: a 4-bank instance with the fill engine
// and a 2-bank instance without it, checked through read-data scoreboards.
module tb_m3ds_sram_bank_array;
  logic clk = 1'b0;
  logic rst_na;
  logic rst_nb;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic pend_a = 1'b0;
  logic pend_b = 1'b0;

  always #5 clk = ~clk;

  m3ds_sram_bank_array_if #(.AW(14)) a_if();
  m3ds_sram_bank_array_if #(.AW(11)) b_if();

  m3ds_sram_bank_array #(
    .BANK_AW    (12),
    .NUM_BANKS  (4),
    .INIT_EN    (1'b1),
    .INIT_VALUE (32'h0000_0000)
  ) u_a (
    .SRAMHCLK    (clk),
    .SRAMHRESETn (rst_na),
    .bus         (a_if.slave)
  );

  m3ds_sram_bank_array #(
    .BANK_AW    (10),
    .NUM_BANKS  (2),
    .INIT_EN    (1'b0),
    .INIT_VALUE (32'h0000_0000)
  ) u_b (
    .SRAMHCLK    (clk),
    .SRAMHRESETn (rst_nb),
    .bus         (b_if.slave)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // a read issued at this edge owes one data word at the next falling edge
  always @(posedge clk) begin
    pend_a <= a_if.SRAMCS && (a_if.SRAMWREN == 4'h0);
    pend_b <= b_if.SRAMCS && (b_if.SRAMWREN == 4'h0);
  end

  always @(negedge clk) begin
    if (pend_a) begin
      if (exp_a.size() == 0) begin
        n_chk++;
        $display("FAIL sb_a: unexpected read %h", a_if.SRAMRDATA);
      end else begin
        check("sb_a", a_if.SRAMRDATA, exp_a.pop_front());
      end
    end
    if (pend_b) begin
      if (exp_b.size() == 0) begin
        n_chk++;
        $display("FAIL sb_b: unexpected read %h", b_if.SRAMRDATA);
      end else begin
        check("sb_b", b_if.SRAMRDATA, exp_b.pop_front());
      end
    end
  end

  task automatic acc_a(input logic [13:0] ad, input logic [3:0] we,
                       input logic [31:0] wd, input logic [31:0] ex);
    a_if.SRAMCS    = 1'b1;
    a_if.SRAMADDR  = ad;
    a_if.SRAMWREN  = we;
    a_if.SRAMWDATA = wd;
    if (we == 4'h0) exp_a.push_back(ex);
    @(negedge clk);
    a_if.SRAMCS = 1'b0;
  endtask

  task automatic acc_b(input logic [10:0] ad, input logic [3:0] we,
                       input logic [31:0] wd, input logic [31:0] ex);
    b_if.SRAMCS    = 1'b1;
    b_if.SRAMADDR  = ad;
    b_if.SRAMWREN  = we;
    b_if.SRAMWDATA = wd;
    if (we == 4'h0) exp_b.push_back(ex);
    @(negedge clk);
    b_if.SRAMCS = 1'b0;
  endtask

  task automatic idle_a(input int n);
    a_if.SRAMCS = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_initreq_a();
    a_if.SRAMCS  = 1'b0;
    a_if.INITREQ = 1'b1;
    @(negedge clk);
    a_if.INITREQ = 1'b0;
  endtask

  task automatic wait_ready_a(input int start, output int edges);
    edges = start;
    while (edges < 6000) begin
      @(posedge clk);
      edges++;
      #1;
      if (a_if.SRAMREADY) break;
    end
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int edges;
    rst_na = 1'b0;
    rst_nb = 1'b0;
    a_if.SRAMCS = 1'b0; a_if.SRAMWREN = 4'h0; a_if.SRAMADDR = '0;
    a_if.SRAMWDATA = '0; a_if.INITREQ = 1'b0;
    b_if.SRAMCS = 1'b0; b_if.SRAMWREN = 4'h0; b_if.SRAMADDR = '0;
    b_if.SRAMWDATA = '0; b_if.INITREQ = 1'b0;
    repeat (3) @(negedge clk);
    check("a_rst_ready", 32'(a_if.SRAMREADY), 32'd0);
    check("a_rst_rdata", a_if.SRAMRDATA, 32'h0);
    check("b_rst_ready", 32'(b_if.SRAMREADY), 32'd1);

    // no-init build: usable straight away, INITREQ ignored
    rst_nb = 1'b1;
    @(negedge clk);
    check("b_ready", 32'(b_if.SRAMREADY), 32'd1);
    acc_b(11'h7FF, 4'hF, 32'hA5A5_0F0F, 32'h0);
    acc_b(11'h7FF, 4'h0, 32'h0, 32'hA5A5_0F0F);
    b_if.INITREQ = 1'b1;
    @(negedge clk);
    b_if.INITREQ = 1'b0;
    check("b_ready_after_initreq", 32'(b_if.SRAMREADY), 32'd1);
    acc_b(11'h3FF, 4'hF, 32'h0123_4567, 32'h0);
    acc_b(11'h7FF, 4'h0, 32'h0, 32'hA5A5_0F0F);
    acc_b(11'h3FF, 4'h0, 32'h0, 32'h0123_4567);
    acc_b(11'h7FF, 4'h0, 32'h0, 32'hA5A5_0F0F);
    b_if.SRAMCS = 1'b0;

    // 4-bank build: fill after reset
    rst_na = 1'b1;
    wait_ready_a(0, edges);
    check("a_reset_fill_edges", 32'(edges), 32'd4096);
    check("a_rdata_first_ready", a_if.SRAMRDATA, 32'h0);
    acc_a(14'h0000, 4'h0, 32'h0, 32'h0);
    acc_a(14'h1FFF, 4'h0, 32'h0, 32'h0);
    acc_a(14'h3FFF, 4'h0, 32'h0, 32'h0);

    acc_a(14'h3FFF, 4'hF, 32'hDEAD_BEEF, 32'h0);
    acc_a(14'h0000, 4'hF, 32'h1234_5678, 32'h0);
    acc_a(14'h3FFF, 4'h0, 32'h0, 32'hDEAD_BEEF);
    acc_a(14'h0000, 4'h0, 32'h0, 32'h1234_5678);
    acc_a(14'h3FFF, 4'h0, 32'h0, 32'hDEAD_BEEF);

    acc_a(14'h1004, 4'hF, 32'hFFFF_FFFF, 32'h0);
    acc_a(14'h1004, 4'h1, 32'h0000_00AA, 32'h0);
    acc_a(14'h1004, 4'h0, 32'h0, 32'hFFFF_FFAA);
    idle_a(1);
    check("a_hold_rdata", a_if.SRAMRDATA, 32'hFFFF_FFAA);
    acc_a(14'h0004, 4'h0, 32'h0, 32'h0);
    acc_a(14'h2004, 4'h0, 32'h0, 32'h0);
    acc_a(14'h3004, 4'h0, 32'h0, 32'h0);

    // requested re-fill; write and second request inside the fill are ignored
    pulse_initreq_a();
    check("a_initreq_ready", 32'(a_if.SRAMREADY), 32'd0);
    idle_a(5);
    acc_a(14'h2000, 4'hF, 32'hCAFE_F00D, 32'h0);
    pulse_initreq_a();
    idle_a(1);
    wait_ready_a(8, edges);
    check("a_initreq_fill_edges", 32'(edges), 32'd4096);
    idle_a(1);
    acc_a(14'h3FFF, 4'h0, 32'h0, 32'h0);
    acc_a(14'h0000, 4'h0, 32'h0, 32'h0);
    acc_a(14'h1004, 4'h0, 32'h0, 32'h0);
    acc_a(14'h2000, 4'h0, 32'h0, 32'h0);

    // reset in the middle of a fill restarts it from scratch
    pulse_initreq_a();
    idle_a(100);
    rst_na = 1'b0;
    #1;
    check("a_midreset_ready", 32'(a_if.SRAMREADY), 32'd0);
    check("a_midreset_rdata", a_if.SRAMRDATA, 32'h0);
    repeat (3) @(negedge clk);
    rst_na = 1'b1;
    wait_ready_a(0, edges);
    check("a_midreset_fill_edges", 32'(edges), 32'd4096);
    idle_a(1);
    acc_a(14'h2ABC, 4'hF, 32'h55AA_55AA, 32'h0);
    acc_a(14'h2ABC, 4'h0, 32'h0, 32'h55AA_55AA);
    acc_a(14'h0ABC, 4'h0, 32'h0, 32'h0);
    idle_a(2);

    check("a_sb_drained", 32'(exp_a.size()), 32'd0);
    check("b_sb_drained", 32'(exp_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
